pc_unit_ras: RTL and testbench

//  Parametrised next-generation program counter for the simple CPU fetch stage.

---
 rtl/pc_unit_ras.sv | 153 +++++++++++++++
 tb/tb_pc_unit_ras.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with exception entry/return and a circular
// return-address stack that predicts procedure returns and flags mispredictions.
module pc_unit_ras #(
  parameter int unsigned XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VEC   = 32'h0000_0100,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic            alu_branch,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            call,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_addr,
  input  logic            ret,
  input  logic            exception,
  input  logic            eret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            ras_mispredict
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);
  localparam logic [XLEN-1:0] ZERO_WORD = XLEN'(1'b0);
  localparam logic [PW-1:0]   PTR_ONE   = PW'(1'b1);
  localparam logic [PW-1:0]   PTR_ZERO  = PW'(1'b0);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(1'b0);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(RAS_DEPTH);

  // Every address that lands in the PC is word aligned.
  function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  logic [XLEN-1:0] pc_r, pc_n_s;
  logic [XLEN-1:0] epc_r, epc_n_s;
  logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
  logic [XLEN-1:0] ras_mem_n_s [RAS_DEPTH];
  logic [PW-1:0]   top_ptr_r, top_ptr_n_s;
  logic [CW-1:0]   count_r, count_n_s;
  logic [XLEN-1:0] ras_top_r, ras_top_n_s;
  logic            ras_valid_r, ras_valid_n_s;
  logic            mispredict_r, mispredict_n_s;
  logic [XLEN-1:0] link_addr_s;
  logic [XLEN-1:0] ret_target_s;
  logic            ras_empty_s;

  assign link_addr_s  = pc_r + PC_STEP;
  assign ret_target_s = align_addr(jr_addr);
  assign ras_empty_s  = (count_r == CNT_ZERO);

  // Next-state arbitration for PC, EPC and the return-address stack.
  always_comb begin
    pc_n_s         = link_addr_s;
    epc_n_s        = epc_r;
    ras_mem_n_s    = ras_mem_r;
    top_ptr_n_s    = top_ptr_r;
    count_n_s      = count_r;
    mispredict_n_s = 1'b0;

    if (exception) begin
      epc_n_s = pc_r;
      pc_n_s  = align_addr(EXC_VEC);
    end else if (eret) begin
      pc_n_s = align_addr(epc_r);
    end else if (stall) begin
      pc_n_s = pc_r;
    end else if (branch && alu_branch) begin
      pc_n_s = align_addr(pc_r + branch_offset + PC_STEP);
    end else if (jump) begin
      pc_n_s = align_addr(jump_addr);
      if (call) begin
        // A push on a full stack simply overwrites the oldest slot.
        top_ptr_n_s              = top_ptr_r + PTR_ONE;
        ras_mem_n_s[top_ptr_n_s] = align_addr(link_addr_s);
        if (count_r == CNT_FULL) begin
          count_n_s = CNT_FULL;
        end else begin
          count_n_s = count_r + CNT_ONE;
        end
      end else begin
        count_n_s = count_r;
      end
    end else if (jr) begin
      pc_n_s = ret_target_s;
      if (ret) begin
        if (ras_empty_s) begin
          mispredict_n_s = 1'b1;
        end else begin
          mispredict_n_s = (ras_mem_r[top_ptr_r] != ret_target_s);
          top_ptr_n_s    = top_ptr_r - PTR_ONE;
          count_n_s      = count_r - CNT_ONE;
        end
      end else begin
        mispredict_n_s = 1'b0;
      end
    end else begin
      pc_n_s = link_addr_s;
    end

    ras_valid_n_s = (count_n_s != CNT_ZERO);
    if (count_n_s == CNT_ZERO) begin
      ras_top_n_s = ZERO_WORD;
    end else begin
      ras_top_n_s = ras_mem_n_s[top_ptr_n_s];
    end
  end

  // State registers; reset overrides stall and exception.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= align_addr(RESET_VEC);
      epc_r        <= ZERO_WORD;
      top_ptr_r    <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      ras_top_r    <= ZERO_WORD;
      ras_valid_r  <= 1'b0;
      mispredict_r <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= ZERO_WORD;
      end
    end else begin
      pc_r         <= pc_n_s;
      epc_r        <= epc_n_s;
      top_ptr_r    <= top_ptr_n_s;
      count_r      <= count_n_s;
      ras_top_r    <= ras_top_n_s;
      ras_valid_r  <= ras_valid_n_s;
      mispredict_r <= mispredict_n_s;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= ras_mem_n_s[i];
      end
    end
  end

  assign pc             = pc_r;
  assign epc            = epc_r;
  assign ras_top        = ras_top_r;
  assign ras_valid      = ras_valid_r;
  assign ras_mispredict = mispredict_r;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed self-checking bench for pc_unit_ras with hand-computed expectations.
module tb_pc_unit_ras;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        alu_branch;
  logic [31:0] branch_offset;
  logic        jump;
  logic [31:0] jump_addr;
  logic        call;
  logic        jr;
  logic [31:0] jr_addr;
  logic        ret;
  logic        exception;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [31:0] ras_top;
  logic        ras_valid;
  logic        ras_mispredict;

  int vec_cnt;
  int err_cnt;

  pc_unit_ras dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .alu_branch(alu_branch),
    .branch_offset(branch_offset), .jump(jump), .jump_addr(jump_addr), .call(call),
    .jr(jr), .jr_addr(jr_addr), .ret(ret), .exception(exception), .eret(eret),
    .pc(pc), .epc(epc), .ras_top(ras_top), .ras_valid(ras_valid),
    .ras_mispredict(ras_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    rst = 1'b0; stall = 1'b0; branch = 1'b0; alu_branch = 1'b0; branch_offset = 32'h0;
    jump = 1'b0; jump_addr = 32'h0; call = 1'b0; jr = 1'b0; jr_addr = 32'h0;
    ret = 1'b0; exception = 1'b0; eret = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic do_jump(input logic [31:0] addr, input logic is_call);
    jump = 1'b1; jump_addr = addr; call = is_call;
    step();
  endtask

  task automatic do_ret(input logic [31:0] addr);
    jr = 1'b1; jr_addr = addr; ret = 1'b1;
    step();
  endtask

  logic [31:0] ret_addr [5];
  logic [31:0] top_after [5];

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    clear_in();

    // 1: reset and sequential fetch
    rst = 1'b1; step(); rst = 1'b1; step();
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_epc", epc, 32'h0);
    check_val("rst_valid", {31'h0, ras_valid}, 32'h0);
    check_val("rst_top", ras_top, 32'h0);
    check_val("rst_mis", {31'h0, ras_mispredict}, 32'h0);
    step(); check_val("seq_pc4", pc, 32'h4);
    step(); check_val("seq_pc8", pc, 32'h8);
    step(); check_val("seq_pc12", pc, 32'hC);

    // 2: branch taken / not taken
    rst = 1'b1; step(); step(); step();
    check_val("pre_br_pc", pc, 32'h8);
    branch = 1'b1; alu_branch = 1'b1; branch_offset = 32'hFFFF_FFF4; step();
    check_val("br_taken", pc, 32'h0);
    step(); step();
    branch = 1'b1; alu_branch = 1'b0; branch_offset = 32'hFFFF_FFF4; step();
    check_val("br_not_taken", pc, 32'hC);

    // 3: call / return prediction
    do_jump(32'h40, 1'b0);
    do_jump(32'h200, 1'b1);
    check_val("call_pc", pc, 32'h200);
    check_val("call_top", ras_top, 32'h44);
    check_val("call_valid", {31'h0, ras_valid}, 32'h1);
    do_ret(32'h44);
    check_val("ret_ok_pc", pc, 32'h44);
    check_val("ret_ok_mis", {31'h0, ras_mispredict}, 32'h0);
    check_val("ret_ok_valid", {31'h0, ras_valid}, 32'h0);
    do_jump(32'h40, 1'b0);
    do_jump(32'h200, 1'b1);
    do_ret(32'h48);
    check_val("ret_bad_pc", pc, 32'h48);
    check_val("ret_bad_mis", {31'h0, ras_mispredict}, 32'h1);
    step();
    check_val("mis_pulse_clr", {31'h0, ras_mispredict}, 32'h0);
    check_val("after_mis_pc", pc, 32'h4C);

    // 4: overflow then drain past empty
    do_jump(32'h1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_jump(32'h2000 + 32'h1000 * i, 1'b1);
    end
    check_val("full_top", ras_top, 32'h5004);
    ret_addr  = '{32'h5004, 32'h4004, 32'h3004, 32'h2004, 32'h1004};
    top_after = '{32'h4004, 32'h3004, 32'h2004, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      do_ret(ret_addr[i]);
      check_val($sformatf("drain%0d_pc", i), pc, ret_addr[i]);
      check_val($sformatf("drain%0d_top", i), ras_top, top_after[i]);
      check_val($sformatf("drain%0d_mis", i), {31'h0, ras_mispredict}, (i == 4) ? 32'h1 : 32'h0);
    end
    check_val("drain_valid", {31'h0, ras_valid}, 32'h0);
    stall = 1'b1; step();
    check_val("stall_clr_mis", {31'h0, ras_mispredict}, 32'h0);

    // 5: exception, eret, arbitration, alignment
    do_jump(32'h20, 1'b0);
    stall = 1'b1; exception = 1'b1; step();
    check_val("exc_epc", epc, 32'h20);
    check_val("exc_pc", pc, 32'h100);
    eret = 1'b1; step();
    check_val("eret_pc", pc, 32'h20);
    branch = 1'b1; alu_branch = 1'b1; branch_offset = 32'h10; jump = 1'b1; jump_addr = 32'h800; step();
    check_val("br_over_jump", pc, 32'h34);
    exception = 1'b1; eret = 1'b1; step();
    check_val("exc_over_eret_pc", pc, 32'h100);
    check_val("exc_over_eret_epc", epc, 32'h34);
    do_jump(32'h203, 1'b0);
    check_val("align_pc", pc, 32'h200);

    // 6: stall holds everything, reset mid-stall
    do_jump(32'h300, 1'b1);
    check_val("pre_stall_top", ras_top, 32'h204);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; jump = 1'b1; jump_addr = 32'h900; call = 1'b1; step();
      check_val($sformatf("stall%0d_pc", i), pc, 32'h300);
      check_val($sformatf("stall%0d_top", i), ras_top, 32'h204);
    end
    stall = 1'b1; rst = 1'b1; step();
    check_val("rst_stall_pc", pc, 32'h0);
    check_val("rst_stall_valid", {31'h0, ras_valid}, 32'h0);
    check_val("rst_stall_epc", epc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
